fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer that feeds the instruction queue. Holds the fetch PC and

---
 rtl/fetch_ctrl_if.sv | 33 +++
 rtl/fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_ctrl_if                                                    |
// | Brief    : Icache request/response, queue push and redirect bundle.         |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fetch_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int INS_W = 32
);
    logic             icache_req;
    logic [PC_W-1:0]  icache_addr;
    logic             icache_valid;
    logic [INS_W-1:0] icache_ins;
    logic             insq_full;
    logic             push;
    logic [INS_W-1:0] push_ins;
    logic [PC_W-1:0]  push_pc;
    logic             jump_en;
    logic [PC_W-1:0]  jump_pc;
    logic             insq_clear;

    modport master (
        output icache_req, icache_addr, push, push_ins, push_pc, insq_clear,
        input  icache_valid, icache_ins, insq_full, jump_en, jump_pc
    );

    modport slave (
        input  icache_req, icache_addr, push, push_ins, push_pc, insq_clear,
        output icache_valid, icache_ins, insq_full, jump_en, jump_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_ctrl                                                       |
// | Brief    : Single-outstanding instruction fetch sequencer with redirect.    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_ctrl #(
    parameter int              PC_W     = 32,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       ready,
    fetch_ctrl_if.master    bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;
    localparam logic [1:0] c_DROP = 2'd3;

    logic [1:0]       state_q,       state_d;
    logic [PC_W-1:0]  pc_q,          pc_d;
    logic [INS_W-1:0] held_q,        held_d;
    logic             icache_req_q,  icache_req_d;
    logic [PC_W-1:0]  icache_addr_q, icache_addr_d;
    logic             push_q,        push_d;
    logic [INS_W-1:0] push_ins_q,    push_ins_d;
    logic [PC_W-1:0]  push_pc_q,     push_pc_d;
    logic             insq_clear_q,  insq_clear_d;

    logic [PC_W-1:0]  w_pc_inc;

    assign w_pc_inc = pc_q + PC_W'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= c_IDLE;
            pc_q          <= RESET_PC;
            held_q        <= '0;
            icache_req_q  <= 1'b0;
            icache_addr_q <= '0;
            push_q        <= 1'b0;
            push_ins_q    <= '0;
            push_pc_q     <= '0;
            insq_clear_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            held_q        <= held_d;
            icache_req_q  <= icache_req_d;
            icache_addr_q <= icache_addr_d;
            push_q        <= push_d;
            push_ins_q    <= push_ins_d;
            push_pc_q     <= push_pc_d;
            insq_clear_q  <= insq_clear_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ready) begin
            if (bus.jump_en) begin
                case (state_q)
                    c_WAIT:  state_d = bus.icache_valid ? c_IDLE : c_DROP;
                    c_DROP:  state_d = c_DROP;
                    default: state_d = c_IDLE;
                endcase
            end else begin
                case (state_q)
                    c_IDLE: if (!bus.insq_full) state_d = c_WAIT;
                    c_WAIT: if (bus.icache_valid) state_d = bus.insq_full ? c_HOLD : c_WAIT;
                    c_HOLD: if (!bus.insq_full) state_d = c_WAIT;
                    default: if (bus.icache_valid) state_d = c_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        pc_d          = pc_q;
        held_d        = held_q;
        icache_req_d  = icache_req_q;
        icache_addr_d = icache_addr_q;
        push_d        = 1'b0;
        push_ins_d    = push_ins_q;
        push_pc_d     = push_pc_q;
        insq_clear_d  = 1'b0;
        if (ready) begin
            if (bus.jump_en) begin
                pc_d         = bus.jump_pc;
                insq_clear_d = 1'b1;
                // A redirect out of DROP keeps the stale request open until it returns.
                if (state_d == c_IDLE) icache_req_d = 1'b0;
            end else begin
                case (state_q)
                    c_IDLE: begin
                        if (!bus.insq_full) begin
                            icache_req_d  = 1'b1;
                            icache_addr_d = pc_q;
                        end
                    end
                    c_WAIT: begin
                        if (bus.icache_valid) begin
                            if (!bus.insq_full) begin
                                push_d        = 1'b1;
                                push_ins_d    = bus.icache_ins;
                                push_pc_d     = pc_q;
                                pc_d          = w_pc_inc;
                                icache_addr_d = w_pc_inc;
                            end else begin
                                held_d       = bus.icache_ins;
                                icache_req_d = 1'b0;
                            end
                        end
                    end
                    c_HOLD: begin
                        if (!bus.insq_full) begin
                            push_d        = 1'b1;
                            push_ins_d    = held_q;
                            push_pc_d     = pc_q;
                            pc_d          = w_pc_inc;
                            icache_req_d  = 1'b1;
                            icache_addr_d = w_pc_inc;
                        end
                    end
                    default: begin
                        if (bus.icache_valid) icache_req_d = 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.icache_req  = icache_req_q;
    assign bus.icache_addr = icache_addr_q;
    assign bus.push        = push_q;
    assign bus.push_ins    = push_ins_q;
    assign bus.push_pc     = push_pc_q;
    assign bus.insq_clear  = insq_clear_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_ctrl                                                    |
// | Brief    : Scoreboarded bench with a latency-programmable icache model.     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_ctrl;
    localparam int PC_W  = 32;
    localparam int INS_W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ready = 1'b1;

    fetch_ctrl_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

    fetch_ctrl #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .ready (ready),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;
    int lat = 1;
    logic [PC_W+INS_W-1:0] exp_q [$];

    function automatic logic [INS_W-1:0] ins_of(input logic [PC_W-1:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    // Icache model: latches a request at a falling edge, answers lat cycles later.
    logic            c_busy;
    int              c_cnt;
    logic [PC_W-1:0] c_addr;
    always @(negedge clk) begin
        if (!reset) begin
            c_busy = 1'b0;
            c_cnt  = 0;
            c_addr = '0;
            bus.icache_valid = 1'b0;
            bus.icache_ins   = '0;
        end else begin
            if (bus.icache_valid) begin
                bus.icache_valid = 1'b0;
                c_busy = 1'b0;
            end else if (c_busy) begin
                c_cnt = c_cnt - 1;
                if (c_cnt == 0) begin
                    bus.icache_valid = 1'b1;
                    bus.icache_ins   = ins_of(c_addr);
                end
            end
            if (!c_busy && bus.icache_req) begin
                c_addr = bus.icache_addr;
                c_busy = 1'b1;
                c_cnt  = lat;
            end
        end
    end

    task automatic exp_push(input logic [PC_W-1:0] pc);
        exp_q.push_back({pc, ins_of(pc)});
    endtask

    // Advance one cycle and retire any push against the scoreboard.
    task automatic cycle();
        logic [PC_W+INS_W-1:0] e;
        @(negedge clk);
        if (bus.push === 1'b1) begin
            vec++;
            if (exp_q.size() == 0) begin
                err++;
                $display("FAIL push_unexpected: got pc=%h ins=%h, required no push", bus.push_pc, bus.push_ins);
            end else begin
                e = exp_q.pop_front();
                if ({bus.push_pc, bus.push_ins} !== e) begin
                    err++;
                    $display("FAIL push_data: got pc=%h ins=%h, required pc=%h ins=%h",
                             bus.push_pc, bus.push_ins, e[PC_W+INS_W-1:INS_W], e[INS_W-1:0]);
                end
            end
        end
    endtask

    task automatic check_drained(input string name);
        vec++;
        if (exp_q.size() != 0) begin
            err++;
            $display("FAIL %s_missing_push: got %0d pushes outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        ready = 1'b1;
        bus.insq_full = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_pc   = '0;
        lat = 1;
        cycle();
        cycle();
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ready = 1'b1;
        bus.insq_full = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_pc   = '0;
        repeat (3) cycle();
        vec++;
        if ({bus.icache_req, bus.push, bus.insq_clear} !== 3'b000) begin
            err++;
            $display("FAIL reset_ctrl: got req=%b push=%b clear=%b, required 0 0 0",
                     bus.icache_req, bus.push, bus.insq_clear);
        end
        vec++;
        if ({bus.icache_addr, bus.push_pc, bus.push_ins} !== 96'h0) begin
            err++;
            $display("FAIL reset_data: got addr=%h pc=%h ins=%h, required all 0",
                     bus.icache_addr, bus.push_pc, bus.push_ins);
        end
    endtask

    task automatic test_basic();
        int last = -1;
        int n = 0;
        apply_reset();
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        for (int i = 1; i <= 7; i++) begin
            cycle();
            if (i == 1) begin
                vec++;
                if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h0) begin
                    err++;
                    $display("FAIL basic_first_req: got req=%b addr=%h, required 1 00000000", bus.icache_req, bus.icache_addr);
                end
            end
            if (bus.push === 1'b1) begin
                n++;
                if (n == 1) begin
                    vec++;
                    if (i != 3) begin
                        err++;
                        $display("FAIL basic_first_push: got cycle %0d, required 3", i);
                    end
                end else begin
                    vec++;
                    if (i - last != 2) begin
                        err++;
                        $display("FAIL basic_spacing: got %0d cycles, required 2", i - last);
                    end
                end
                vec++;
                if (bus.icache_req !== 1'b1 || bus.icache_addr !== bus.push_pc + 32'd4) begin
                    err++;
                    $display("FAIL basic_next_req: got req=%b addr=%h, required 1 %h",
                             bus.icache_req, bus.icache_addr, bus.push_pc + 32'd4);
                end
                last = i;
            end
        end
        check_drained("basic");
    endtask

    task automatic test_hold();
        apply_reset();
        for (int k = 0; k < 6; k++) exp_push(32'(k * 4));
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (i >= 11 && i <= 13) begin
                vec++;
                if (bus.icache_req !== 1'b0 || bus.push !== 1'b0) begin
                    err++;
                    $display("FAIL hold_stall: got req=%b push=%b at cycle %0d, required 0 0", bus.icache_req, bus.push, i);
                end
            end
            if (i == 14) begin
                vec++;
                if (bus.push !== 1'b1 || bus.push_pc !== 32'h10 || bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h14) begin
                    err++;
                    $display("FAIL hold_release: got push=%b pc=%h req=%b addr=%h, required 1 00000010 1 00000014",
                             bus.push, bus.push_pc, bus.icache_req, bus.icache_addr);
                end
            end
            if (i == 9)  bus.insq_full = 1'b1;
            if (i == 13) bus.insq_full = 1'b0;
        end
        check_drained("hold");
    endtask

    task automatic test_jump_wait();
        logic exp_clr;
        apply_reset();
        lat = 2;
        exp_push(32'h0); exp_push(32'h200);
        for (int i = 1; i <= 11; i++) begin
            cycle();
            exp_clr = (i == 5);
            vec++;
            if (bus.insq_clear !== exp_clr) begin
                err++;
                $display("FAIL jwait_clear: got %b at cycle %0d, required %b", bus.insq_clear, i, exp_clr);
            end
            if (i == 5) begin
                vec++;
                if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h4) begin
                    err++;
                    $display("FAIL jwait_drop_req: got req=%b addr=%h, required 1 00000004", bus.icache_req, bus.icache_addr);
                end
            end
            if (i == 7) begin
                vec++;
                if (bus.icache_req !== 1'b0) begin
                    err++;
                    $display("FAIL jwait_idle: got req=%b, required 0", bus.icache_req);
                end
            end
            if (i == 8) begin
                vec++;
                if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h200) begin
                    err++;
                    $display("FAIL jwait_target: got req=%b addr=%h, required 1 00000200", bus.icache_req, bus.icache_addr);
                end
            end
            if (i == 4) begin bus.jump_pc = 32'h200; bus.jump_en = 1'b1; end
            if (i == 5) bus.jump_en = 1'b0;
        end
        check_drained("jwait");
    endtask

    task automatic test_jump_valid();
        logic exp_clr;
        apply_reset();
        exp_push(32'h0); exp_push(32'h400);
        for (int i = 1; i <= 15; i++) begin
            cycle();
            exp_clr = (i == 5) || (i == 7) || (i == 8);
            vec++;
            if (bus.insq_clear !== exp_clr) begin
                err++;
                $display("FAIL jvalid_clear: got %b at cycle %0d, required %b", bus.insq_clear, i, exp_clr);
            end
            if (i == 5) begin
                vec++;
                if (bus.icache_req !== 1'b0 || bus.push !== 1'b0) begin
                    err++;
                    $display("FAIL jvalid_discard: got req=%b push=%b, required 0 0", bus.icache_req, bus.push);
                end
            end
            if (i == 6) begin
                vec++;
                if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h200) begin
                    err++;
                    $display("FAIL jvalid_target: got req=%b addr=%h, required 1 00000200", bus.icache_req, bus.icache_addr);
                end
            end
            if (i == 11) begin
                vec++;
                if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h400) begin
                    err++;
                    $display("FAIL jdrop_latest: got req=%b addr=%h, required 1 00000400", bus.icache_req, bus.icache_addr);
                end
            end
            if (i == 4) begin bus.jump_pc = 32'h200; bus.jump_en = 1'b1; end
            if (i == 5) begin bus.jump_en = 1'b0; lat = 3; end
            if (i == 6) begin bus.jump_pc = 32'h300; bus.jump_en = 1'b1; end
            if (i == 7) bus.jump_pc = 32'h400;
            if (i == 8) bus.jump_en = 1'b0;
        end
        check_drained("jvalid");
    endtask

    task automatic test_ready();
        apply_reset();
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8); exp_push(32'hC);
        for (int i = 1; i <= 13; i++) begin
            cycle();
            if (i >= 6 && i <= 10) begin
                vec++;
                if (bus.push !== 1'b0 || bus.insq_clear !== 1'b0 || bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h8) begin
                    err++;
                    $display("FAIL ready_freeze: got push=%b clear=%b req=%b addr=%h at cycle %0d, required 0 0 1 00000008",
                             bus.push, bus.insq_clear, bus.icache_req, bus.icache_addr, i);
                end
            end
            if (i == 11) begin
                vec++;
                if (bus.push !== 1'b1 || bus.push_pc !== 32'h8) begin
                    err++;
                    $display("FAIL ready_resume: got push=%b pc=%h, required 1 00000008", bus.push, bus.push_pc);
                end
            end
            if (i == 5)  ready = 1'b0;
            if (i == 7)  begin bus.jump_pc = 32'h500; bus.jump_en = 1'b1; end
            if (i == 8)  bus.jump_en = 1'b0;
            if (i == 10) ready = 1'b1;
        end
        check_drained("ready");
    endtask

    task automatic test_wrap_reset();
        apply_reset();
        exp_push(32'h0); exp_push(32'hFFFF_FFFC); exp_push(32'h0);
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 6) begin
                vec++;
                if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'hFFFF_FFFC) begin
                    err++;
                    $display("FAIL wrap_target: got req=%b addr=%h, required 1 fffffffc", bus.icache_req, bus.icache_addr);
                end
            end
            if (i == 8 || i == 10) begin
                vec++;
                if (bus.icache_addr !== ((i == 8) ? 32'h0 : 32'h4)) begin
                    err++;
                    $display("FAIL wrap_addr: got %h at cycle %0d, required %h", bus.icache_addr, i, (i == 8) ? 32'h0 : 32'h4);
                end
            end
            if (i == 3) begin bus.jump_pc = 32'hFFFF_FFFC; bus.jump_en = 1'b1; end
            if (i == 4) bus.jump_en = 1'b0;
        end
        check_drained("wrap");
        #2 reset = 1'b0;
        #1;
        vec++;
        if ({bus.icache_req, bus.push, bus.insq_clear} !== 3'b000 ||
            {bus.icache_addr, bus.push_pc, bus.push_ins} !== 96'h0) begin
            err++;
            $display("FAIL async_reset: got req=%b addr=%h push=%b pc=%h ins=%h clear=%b, required all 0",
                     bus.icache_req, bus.icache_addr, bus.push, bus.push_pc, bus.push_ins, bus.insq_clear);
        end
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        vec++;
        if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h0) begin
            err++;
            $display("FAIL reset_pc: got req=%b addr=%h, required 1 00000000", bus.icache_req, bus.icache_addr);
        end
    endtask

    initial begin
        bus.insq_full = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_pc   = '0;
        test_reset();
        test_basic();
        test_hold();
        test_jump_wait();
        test_jump_valid();
        test_ready();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
`default_nettype wire
